// File: rtl/pet2001ps2kbd_if.sv
// rtl/pet2001ps2kbd_if.sv - PS/2 and PIA keyboard port bundle for pet2001ps2kbd
//
// Groups the keyboard front end's signals:
//   ps2_clk, ps2_data : raw PS/2 lines (asynchronous), toward the keyboard front end
//   keyrow            : PIA row select (rows 0-9 valid)
//   keyin             : active-low column read of the selected row
//   key_reset         : one-cycle pulse on F11 make
//   frame_err         : one-cycle pulse when a PS/2 frame is dropped
// master = environment (PS/2 device + PIA), slave = pet2001ps2kbd.
interface pet2001ps2kbd_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [3:0] keyrow;
  logic [7:0] keyin;
  logic       key_reset;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data, keyrow,
    input  keyin, key_reset, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, keyrow,
    output keyin, key_reset, frame_err
  );
endinterface

// File: rtl/pet2001ps2kbd.sv
// rtl/pet2001ps2kbd.sv - PS/2 keyboard to PET 2001 10x8 key matrix front end
//
// Receives PS/2 frames, decodes make/break/extended/pause sequences and keeps
// the PET key matrix that the PIA scans through keyrow/keyin.
//   clk     : system clock, single domain
//   reset_n : asynchronous active-low reset (deassertion synchronized here)
//   kbd     : slave side of pet2001ps2kbd_if (ps2_clk, ps2_data, keyrow in;
//             keyin, key_reset, frame_err out)
module pet2001ps2kbd #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pet2001ps2kbd_if.slave       kbd
);

  localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BRK,
    ST_EXT,
    ST_EXTBRK,
    ST_SKIP
  } state_t;

  // Reset: asynchronous assert, synchronous deassert.
  logic [1:0] rst_sync_q;
  logic       rst_n_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_q = rst_sync_q[1];

  // Input synchronizers and PS/2 clock glitch filter.
  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic          strobe_q;

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      strobe_q   <= 1'b0;
    end else begin
      clk_s1_q <= kbd.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= kbd.ps2_data;
      dat_s2_q <= dat_s1_q;
      strobe_q <= 1'b0;
      if (clk_s2_q == filt_q) begin
        filt_cnt_q <= '0;
      end else if (filt_cnt_q == FW'(FILTER - 1)) begin
        // FILTER consecutive samples disagreed with the filtered level.
        filt_q     <= clk_s2_q;
        filt_cnt_q <= '0;
        strobe_q   <= filt_q;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
    end
  end

  // Frame receiver: start, 8 data LSB first, odd parity, stop.
  logic [3:0]    bit_cnt_q;
  logic [9:0]    shreg_q;
  logic [10:0]   frame_d;
  logic [TW-1:0] to_cnt_q;
  logic          code_valid_q;
  logic [7:0]    code_q;
  logic          frame_err_q;
  logic          frame_ok;

  assign frame_d  = {dat_s2_q, shreg_q};
  assign frame_ok = !frame_d[0] && (^frame_d[9:1]) && frame_d[10];

  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      to_cnt_q     <= '0;
      code_valid_q <= 1'b0;
      code_q       <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (strobe_q) begin
        // A strobe always wins over a coincident timeout expiry.
        to_cnt_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (frame_ok) begin
            code_valid_q <= 1'b1;
            code_q       <= frame_d[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          shreg_q   <= frame_d[10:1];
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          bit_cnt_q   <= '0;
          to_cnt_q    <= '0;
          frame_err_q <= 1'b1;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
    end
  end

  // Keymap: {ext, code} -> {hit, row, col}.
  state_t     state_q;
  logic [2:0] skip_q;
  logic [7:0] matrix_q [0:9];
  logic       key_reset_q;
  logic       km_ext;
  logic [7:0] km;
  logic       km_hit;
  logic [3:0] km_row;
  logic [2:0] km_col;

  function automatic logic [7:0] k(input logic [3:0] r, input logic [2:0] c);
    return {1'b1, r, c};
  endfunction

  assign km_ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

  always_comb begin
    km = 8'h00;
    case ({km_ext, code_q})
      9'h015: km = k(4'd2, 3'd0);  // Q
      9'h024: km = k(4'd2, 3'd1);  // E
      9'h02C: km = k(4'd2, 3'd2);  // T
      9'h03C: km = k(4'd2, 3'd3);  // U
      9'h044: km = k(4'd2, 3'd4);  // O
      9'h03D: km = k(4'd2, 3'd6);  // 7
      9'h046: km = k(4'd2, 3'd7);  // 9
      9'h01D: km = k(4'd3, 3'd0);  // W
      9'h02D: km = k(4'd3, 3'd1);  // R
      9'h035: km = k(4'd3, 3'd2);  // Y
      9'h043: km = k(4'd3, 3'd3);  // I
      9'h04D: km = k(4'd3, 3'd4);  // P
      9'h03E: km = k(4'd3, 3'd6);  // 8
      9'h04A: km = k(4'd3, 3'd7);  // /
      9'h01C: km = k(4'd4, 3'd0);  // A
      9'h023: km = k(4'd4, 3'd1);  // D
      9'h034: km = k(4'd4, 3'd2);  // G
      9'h03B: km = k(4'd4, 3'd3);  // J
      9'h04B: km = k(4'd4, 3'd4);  // L
      9'h025: km = k(4'd4, 3'd6);  // 4
      9'h036: km = k(4'd4, 3'd7);  // 6
      9'h01B: km = k(4'd5, 3'd0);  // S
      9'h02B: km = k(4'd5, 3'd1);  // F
      9'h033: km = k(4'd5, 3'd2);  // H
      9'h042: km = k(4'd5, 3'd3);  // K
      9'h02E: km = k(4'd5, 3'd6);  // 5
      9'h01A: km = k(4'd6, 3'd0);  // Z
      9'h021: km = k(4'd6, 3'd1);  // C
      9'h032: km = k(4'd6, 3'd2);  // B
      9'h03A: km = k(4'd6, 3'd3);  // M
      9'h04C: km = k(4'd6, 3'd4);  // ;
      9'h05A: km = k(4'd6, 3'd5);  // Return
      9'h016: km = k(4'd6, 3'd6);  // 1
      9'h026: km = k(4'd6, 3'd7);  // 3
      9'h022: km = k(4'd7, 3'd0);  // X
      9'h02A: km = k(4'd7, 3'd1);  // V
      9'h031: km = k(4'd7, 3'd2);  // N
      9'h041: km = k(4'd7, 3'd3);  // ,
      9'h01E: km = k(4'd7, 3'd6);  // 2
      9'h012: km = k(4'd8, 3'd0);  // LShift
      9'h059: km = k(4'd8, 3'd5);  // RShift
      9'h045: km = k(4'd8, 3'd6);  // 0
      9'h04E: km = k(4'd8, 3'd7);  // -
      9'h029: km = k(4'd9, 3'd2);  // Space
      9'h076: km = k(4'd9, 3'd4);  // Esc -> STOP
      9'h049: km = k(4'd9, 3'd6);  // .
      9'h055: km = k(4'd9, 3'd7);  // =
      9'h16B: km = k(4'd1, 3'd7);  // Left  -> CRSR L/R
      9'h174: km = k(4'd1, 3'd7);  // Right -> CRSR L/R
      9'h172: km = k(4'd1, 3'd6);  // Down  -> CRSR U/D
      9'h175: km = k(4'd1, 3'd6);  // Up    -> CRSR U/D
      9'h16C: km = k(4'd0, 3'd6);  // Home
      9'h15A: km = k(4'd6, 3'd5);  // Keypad Enter -> Return
      default: km = 8'h00;
    endcase
  end

  assign km_hit = km[7];
  assign km_row = km[6:3];
  assign km_col = km[2:0];

  // Decoder FSM and key matrix.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q     <= ST_IDLE;
      skip_q      <= '0;
      key_reset_q <= 1'b0;
      for (int r = 0; r < 10; r++) matrix_q[r] <= '0;
    end else begin
      key_reset_q <= 1'b0;
      if (code_valid_q) begin
        unique case (state_q)
          ST_IDLE: begin
            if (code_q == 8'hE0) begin
              state_q <= ST_EXT;
            end else if (code_q == 8'hF0) begin
              state_q <= ST_BRK;
            end else if (code_q == 8'hE1) begin
              // Pause/Break: E1 plus seven more codes carry no key state.
              state_q <= ST_SKIP;
              skip_q  <= 3'd7;
            end else if (code_q == 8'hAA) begin
              for (int r = 0; r < 10; r++) matrix_q[r] <= '0;
            end else begin
              if (km_hit) matrix_q[km_row][km_col] <= 1'b1;
              if (code_q == 8'h78) key_reset_q <= 1'b1;
            end
          end
          ST_EXT: begin
            if (code_q == 8'hF0) begin
              state_q <= ST_EXTBRK;
            end else begin
              if (km_hit) matrix_q[km_row][km_col] <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          ST_BRK, ST_EXTBRK: begin
            if (km_hit) matrix_q[km_row][km_col] <= 1'b0;
            state_q <= ST_IDLE;
          end
          ST_SKIP: begin
            skip_q <= skip_q - 1'b1;
            if (skip_q == 3'd1) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Read side: rows 10-15 read as nothing pressed.
  always_comb begin
    kbd.keyin = 8'hFF;
    for (int r = 0; r < 10; r++) begin
      if (kbd.keyrow == 4'(r)) kbd.keyin = ~matrix_q[r];
    end
  end

  assign kbd.key_reset = key_reset_q;
  assign kbd.frame_err = frame_err_q;

endmodule

// File: doc/pet2001ps2kbd.md
# pet2001ps2kbd

PS/2 keyboard front end for the PET 2001 core. It receives PS/2 frames, decodes make/break/extended sequences and maintains a 10×8 PET key matrix. The PIA keyboard port reads that matrix through the `keyrow`/`keyin` pair on `pet2001hw`. It sits directly upstream of `pet2001hw`: it consumes `keyrow` and produces `keyin`.

## Interface
Parameters:
- FILTER, 8: consecutive equal samples required before the filtered PS/2 clock level changes.
- TIMEOUT, 4096: `clk` cycles without a filtered falling edge after which a partial frame is discarded.

Ports:
- clk  in  1  system clock; all logic is in this single domain.
- reset_n  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous.
- ps2_data  in  1  raw PS/2 data, asynchronous.
- keyrow  in  4  row select from the PIA. Rows 0–9 are valid.
- keyin  out  8  active-low column read for the selected row.
- key_reset  out  1  one-cycle pulse on the F11 make code.
- frame_err  out  1  one-cycle pulse when a frame is dropped.

## Operation
- **Input sync**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer.
  - `ps2_clk` then passes through a glitch filter: the filtered level changes only after FILTER consecutive equal synced samples.
  - A falling edge of the filtered clock is the sample strobe.
- **Frame receiver**
  - Frame format: start bit (0), 8 data bits LSB first, odd parity, stop bit (1).
  - A 4-bit bit counter runs 0–10. On each strobe, synced `ps2_data` is shifted in.
  - The frame is dropped and `frame_err` pulses if any of these hold: start bit = 1, parity of data+parity bit is even, or stop bit = 0.
  - Timeout: a counter clears on every strobe. If it reaches TIMEOUT while the bit counter ≠ 0, the bit counter returns to 0 and `frame_err` pulses.
  - A good frame produces an internal `code_valid` pulse with `code[7:0]`.
- **Decoder FSM**, states IDLE, BRK, EXT, EXTBRK, SKIP:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - E1 → SKIP with skip count 7.
    - AA (keyboard BAT) clears the whole matrix.
    - Any other code is applied as a make.
  - EXT: F0 → EXTBRK. Any other code is applied as an extended make, then → IDLE.
  - BRK: the code is applied as a break, then → IDLE.
  - EXTBRK: the code is applied as an extended break, then → IDLE.
  - SKIP: decrement the skip count on each code; → IDLE when it reaches 0. No matrix change.
  - `frame_err` does not change FSM state.
- **Keymap**
  - Combinational lookup of {ext, code} → {hit, row[3:0], col[2:0]}.
  - A make sets matrix[row][col] = 1; a break clears it. A code with no hit is ignored.
  - Required entries (non-exhaustive):
    - 1C 'A' → row 4, col 0.
    - 5A Return → row 6, col 5.
    - 12 LShift → row 8, col 0.
    - 59 RShift → row 8, col 5.
    - E0 6B Left → row 1, col 7 (CRSR L/R).
    - 29 Space → row 9, col 2.
  - 78 (F11) make: `key_reset` pulses. F11 has no matrix entry.
- **Read side**
  - keyin = ~matrix[keyrow] for keyrow 0–9; 8'hFF for keyrow 10–15.
  - keyin is combinational from the matrix registers and `keyrow`. No ghosting is modelled.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - Matrix cleared, FSM = IDLE, counters = 0, filter state = 1.
  - keyin = 8'hFF, key_reset = 0, frame_err = 0.
- Latency:
  - Cycle N: the strobe that samples the stop bit.
  - Cycle N+1: `code_valid` and `frame_err` assert.
  - Cycle N+2: the matrix update and `key_reset` are visible.
- Filtered edge latency is 2 + FILTER cycles after the raw edge.
- Boundary behaviour:
  - Make of an already-pressed key: no change.
  - Break of a released key: no change.
  - A strobe arriving in the same cycle as the timeout expiry is counted as a bit; the timeout has no effect that cycle.
  - reset_n asserted mid-frame discards the partial frame and clears the matrix.
  - keyrow changing in any cycle updates keyin in the same cycle.

## Test plan
- **Make/break:** send 1C, then F0 1C. keyrow=4 → keyin = 8'hFE after the make, 8'hFF after the break. All other rows read 8'hFF throughout.
- **Extended sequence:** send E0 6B. keyrow=1 → keyin = 8'h7F. Then send E0 F0 6B → 8'hFF. The FSM returns to IDLE after each sequence.
- **Multi-key row:** send 12 and 59. keyrow=8 → keyin = 8'hDE. Break 12 → keyin = 8'hDF.
- **Frame errors:**
  - Send 1C with an even-parity bit: frame_err = 1 for exactly 1 cycle, matrix unchanged.
  - Stop PS/2 clocking after 5 bits, wait TIMEOUT cycles: frame_err pulses. A following good 5A frame gives keyrow=6 → keyin = 8'hDF.
- **Special codes:**
  - Send E1 14 77 E1 F0 14 F0 77, then 29: only row 9 col 2 is set (keyin = 8'hFB).
  - Send AA: all rows read 8'hFF.
  - Send 78: key_reset = 1 for 1 cycle.
- **Reset and glitch:**
  - Assert reset_n low mid-frame: keyin = 8'hFF immediately. A complete frame after release decodes correctly.
  - A 3-cycle low glitch on ps2_clk produces no strobe.
